// File: rtl/otter_intr_pkg.sv
// Shared types, CSR addresses and the priority encoder for otter_intr_ctrl.
package otter_intr_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    REQ    = 2'd1,
    ACTIVE = 2'd2
  } intr_state_t;

  localparam logic [1:0] CSR_ENABLE  = 2'd0;
  localparam logic [1:0] CSR_PENDING = 2'd1;
  localparam logic [1:0] CSR_STATUS  = 2'd2;
  localparam logic [1:0] CSR_RAW     = 2'd3;

  // Index of the lowest set bit; 0 when no bit is set.
  function automatic logic [4:0] prio_enc(input logic [31:0] vec);
    logic [4:0] idx;
    idx = 5'd0;
    for (int i = 31; i >= 0; i--) begin
      if (vec[i]) idx = 5'(i);
    end
    return idx;
  endfunction

endpackage

// File: rtl/otter_intr_sync.sv
// One interrupt line: SYNC_STAGES-deep synchroniser plus a delayed copy for edge detection.
module otter_intr_sync #(
  parameter int SYNC_STAGES = 2
) (
  input  logic clk,
  input  logic rst,
  input  logic async_in,
  output logic sync_out,
  output logic sync_d
);

  logic [SYNC_STAGES-1:0] stages;

  // Shift the raw request through the synchroniser, then keep one older sample.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      stages <= '0;
      sync_d <= 1'b0;
    end else begin
      // NOTE: non-blocking so every stage samples the previous stage's old value.
      stages <= {stages[SYNC_STAGES-2:0], async_in};
      sync_d <= stages[SYNC_STAGES-1];
    end
  end

  assign sync_out = stages[SYNC_STAGES-1];

endmodule

// File: rtl/otter_intr_ctrl.sv
// Multi-source interrupt controller: sync, pending latch, mask, fixed priority,
// REQ/ACK/MRET handshake with the control FSM and a four-word CSR window.
module otter_intr_ctrl
  import otter_intr_pkg::*;
#(
  parameter int               N_SRC       = 8,
  parameter int               SYNC_STAGES = 2,
  parameter logic [N_SRC-1:0] EDGE_MASK   = {N_SRC{1'b1}},
  localparam int              ID_W        = (N_SRC > 1) ? $clog2(N_SRC) : 1
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic [N_SRC-1:0] IRQ_IN,
  input  logic             MIE,
  output logic             INTR,
  output logic [ID_W-1:0]  INTR_ID,
  input  logic             INTR_ACK,
  input  logic             MRET,
  input  logic             CSR_WE,
  input  logic [1:0]       CSR_ADDR,
  input  logic [31:0]      CSR_WD,
  output logic [31:0]      CSR_RD
);

  logic [N_SRC-1:0] sync, sync_d, pending, pending_n, enable, elig, w1c;
  intr_state_t      state, state_n;
  logic [ID_W-1:0]  intr_id, intr_id_n;
  logic             ack_take;

  for (genvar g = 0; g < N_SRC; g++) begin : g_sync
    otter_intr_sync #(.SYNC_STAGES(SYNC_STAGES)) u_sync (
      .clk      (CLK),
      .rst      (RST),
      .async_in (IRQ_IN[g]),
      .sync_out (sync[g]),
      .sync_d   (sync_d[g])
    );
  end

  if (N_SRC < 32) begin : g_wd_sink
    logic unused_wd_hi;
    assign unused_wd_hi = ^CSR_WD[31:N_SRC];
  end

  assign elig     = pending & enable;
  assign ack_take = (state == REQ) && INTR_ACK;
  assign w1c      = (CSR_WE && CSR_ADDR == CSR_PENDING) ? CSR_WD[N_SRC-1:0] : '0;

  // Next pending: edge sources latch rises (set beats clear), level sources follow sync.
  always_comb begin
    // NOTE: default first so no path leaves pending_n unassigned (no latch).
    pending_n = pending;
    for (int i = 0; i < N_SRC; i++) begin
      if (EDGE_MASK[i]) begin
        pending_n[i] = (sync[i] & ~sync_d[i]) |
                       (pending[i] & ~(w1c[i] | (ack_take && intr_id == ID_W'(i))));
      end else begin
        pending_n[i] = sync[i];
      end
    end
  end

  // Pending and enable registers.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      pending <= '0;
      enable  <= '0;
    end else begin
      pending <= pending_n;
      if (CSR_WE && CSR_ADDR == CSR_ENABLE) enable <= CSR_WD[N_SRC-1:0];
    end
  end

  // Handshake state register and the latched source index.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state   <= IDLE;
      intr_id <= '0;
    end else begin
      state   <= state_n;
      intr_id <= intr_id_n;
    end
  end

  // Next state: arbitrate only in IDLE; REQ holds its winner until ACK or withdraw.
  always_comb begin
    state_n   = state;
    intr_id_n = intr_id;
    case (state)
      IDLE: begin
        if (MIE && |elig) begin
          state_n   = REQ;
          intr_id_n = ID_W'(prio_enc(32'(elig)));
        end
      end
      REQ: begin
        if (INTR_ACK)                   state_n = ACTIVE;
        else if (!MIE || !elig[intr_id]) state_n = IDLE;
      end
      ACTIVE: begin
        if (MRET) state_n = IDLE;
      end
      default: state_n = IDLE;
    endcase
  end

  assign INTR    = (state == REQ);
  assign INTR_ID = intr_id;

  // Combinational CSR read mux; unused bits read as zero.
  always_comb begin
    CSR_RD = '0;
    case (CSR_ADDR)
      CSR_ENABLE:  CSR_RD[N_SRC-1:0] = enable;
      CSR_PENDING: CSR_RD[N_SRC-1:0] = pending;
      CSR_STATUS: begin
        CSR_RD[1:0]       = state;
        CSR_RD[8 +: ID_W] = intr_id;
      end
      default:     CSR_RD[N_SRC-1:0] = sync;
    endcase
  end

endmodule

// File: doc/otter_intr_ctrl.md
Name: otter_intr_ctrl

Overview:
- Parametrised multi-source interrupt controller for the OTTER multicycle core; replaces the single raw INTR line into the control FSM.
- Synchronises N_SRC request lines, latches pending edges, masks them per source, and picks a winner by fixed priority (lowest index wins).
- Runs a request/acknowledge/complete handshake with the control FSM.
- Exposes enable/pending/status through a small word-addressed CSR port.

Parameters:
- N_SRC, 8, number of interrupt sources (legal range 1..32).
- SYNC_STAGES, 2, flip-flops in each input synchroniser (legal range 2..4).
- EDGE_MASK, {N_SRC{1'b1}}, per source: 1 means rising-edge triggered, 0 means level triggered.

Ports:
- CLK  in  1  system clock.
- RST  in  1  asynchronous, active-high reset.
- IRQ_IN  in  N_SRC  raw asynchronous interrupt requests.
- MIE  in  1  global interrupt enable from the core CSR.
- INTR  out  1  interrupt request to the control FSM.
- INTR_ID  out  $clog2(N_SRC) (min 1)  index of the requesting/serviced source.
- INTR_ACK  in  1  FSM entered its interrupt state (1-cycle pulse).
- MRET  in  1  handler complete (1-cycle pulse).
- CSR_WE  in  1  CSR write strobe.
- CSR_ADDR  in  2  CSR word select.
- CSR_WD  in  32  CSR write data.
- CSR_RD  out  32  CSR read data (combinational).

Behaviour:
- Reset: all synchroniser flops 0, PENDING 0, ENABLE 0, state IDLE, INTR 0, INTR_ID 0. Reset mid-service drops all pending and active state.
- Synchroniser: each IRQ_IN bit passes through SYNC_STAGES flops, giving sync[i]. One more flop holds sync_d[i] for edge detection.
- Edge source (EDGE_MASK[i]=1):
  - PENDING[i] sets on the cycle sync[i] & ~sync_d[i].
  - PENDING[i] clears on acknowledge of source i, or on a CSR W1C write.
  - If a set and a clear land on the same cycle, set wins.
- Level source (EDGE_MASK[i]=0): PENDING[i] = sync[i] each cycle. Acknowledge and W1C have no effect on it.
- Eligible vector: elig = PENDING & ENABLE. Winner = lowest set index of elig.
- FSM states: IDLE, REQ, ACTIVE.
  - IDLE: if MIE && |elig, latch winner into INTR_ID and go to REQ. Otherwise stay.
  - REQ: INTR=1 and INTR_ID is held stable; there is no re-arbitration, even if a higher-priority source arrives.
    - INTR_ACK=1: go to ACTIVE and clear PENDING[INTR_ID] if it is an edge source.
    - else if MIE==0 or elig[INTR_ID]==0: withdraw to IDLE.
    - If INTR_ACK and the withdraw condition occur together, ACK wins.
  - ACTIVE: INTR=0 and INTR_ID holds the serviced source. No nesting: new requests stay pending. MRET=1 returns to IDLE.
  - MRET outside ACTIVE and INTR_ACK outside REQ are ignored.
- INTR is a registered output, equal to (state==REQ).
- Latency:
  - Rising edge on IRQ_IN, first sampled at clock edge k: PENDING sets at edge k+SYNC_STAGES, and INTR rises after edge k+SYNC_STAGES+1.
  - After MRET, a still-eligible source gives INTR after two edges: IDLE at the first, REQ at the second.
- CSR map (CSR_RD is combinational on CSR_ADDR; writes take effect at the clock edge):
  - 0: ENABLE, read/write over bits [N_SRC-1:0]; upper bits read 0.
  - 1: PENDING. Read returns PENDING; writing 1 clears edge-source bits; writing 0, and any write to level-source bits, is ignored.
  - 2: STATUS, read-only. [1:0] = state (IDLE=0, REQ=1, ACTIVE=2); [12:8] = INTR_ID; other bits 0.
  - 3: RAW, read-only, returns sync vector.
  - Writes to addresses 2 and 3 are ignored.
- Width rule: with N_SRC=1, INTR_ID is 1 bit and always 0.

Decomposition:
- Package otter_intr_pkg holds:
  - state enum intr_state_t {IDLE, REQ, ACTIVE}, encoded 2'd0/1/2;
  - CSR address constants CSR_ENABLE=2'd0, CSR_PENDING=2'd1, CSR_STATUS=2'd2, CSR_RAW=2'd3.
- Sub-module otter_intr_sync: one SYNC_STAGES-deep synchroniser plus edge detector per source, instantiated N_SRC times with generate.
- The priority encoder stays a function in the package.

Test Plan:
- Reset/latency: ENABLE=0x01, MIE=1, pulse IRQ_IN[0] high for 3 cycles -> PENDING reads 0x01 at edge k+2; INTR=1, INTR_ID=0 after edge k+3; STATUS=0x001.
- Priority: ENABLE=0xFF, raise IRQ_IN[5] and IRQ_IN[2] simultaneously -> INTR_ID=2. After ACK, PENDING=0x20. After MRET, INTR rises again with INTR_ID=5.
- Masking/withdraw: in REQ for source 3, write ENABLE=0x00 before ACK -> state returns to IDLE, INTR=0, PENDING still 0x08. Then drop MIE and rewrite ENABLE=0x08 -> no INTR until MIE=1.
- Level vs edge: EDGE_MASK=0xFE, hold IRQ_IN[0] high through ACK and MRET -> INTR re-asserts with INTR_ID=0. W1C of 0x01 leaves PENDING[0]=1.
- Simultaneous set/clear: write PENDING W1C 0x10 on the same cycle a new edge on source 4 is detected -> PENDING[4] stays 1.
- Reset mid-service: assert RST while ACTIVE with PENDING=0x06 -> after reset, STATUS=0, PENDING=0, INTR=0, ENABLE=0.
